// File: rtl/wb_regfile.sv
// Y86 writeback stage: eight-entry program register file with two commit ports,
// two combinational read ports, sticky halt/status latch and retired-instruction counter.
module wb_regfile #(
  parameter int         WIDTH  = 32,
  parameter int         NREGS  = 8,
  parameter logic [7:0] RNONE  = 8'h0F,
  parameter bit         BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W_stall_i,
  input  logic [7:0]       wb_icode,
  input  logic [7:0]       wb_stat,
  input  logic [WIDTH-1:0] wb_valE,
  input  logic [WIDTH-1:0] wb_valM,
  input  logic [7:0]       wb_dstE,
  input  logic [7:0]       wb_dstM,
  input  logic [7:0]       d_srcA,
  input  logic [7:0]       d_srcB,
  output logic [WIDTH-1:0] d_rvalA,
  output logic [WIDTH-1:0] d_rvalB,
  output logic [7:0]       stat_o,
  output logic             halted_o,
  output logic [31:0]      retired_o
);

  localparam int         IDX_W    = $clog2(NREGS);
  localparam logic [7:0] NREGS_ID = 8'(NREGS);
  localparam logic [7:0] STAT_AOK = 8'h01;
  localparam logic [7:0] INOP     = 8'h01;

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic [7:0]       stat_reg;
  logic             halted_reg;
  logic [31:0]      retired_reg;

  logic commit;
  logic commit_aok;
  logic we_e;
  logic we_m;
  logic src_a_ok;
  logic src_b_ok;

  assign commit     = !W_stall_i && !halted_reg;
  assign commit_aok = commit && (wb_stat == STAT_AOK);
  assign we_e       = commit_aok && (wb_dstE != RNONE) && (wb_dstE < NREGS_ID);
  assign we_m       = commit_aok && (wb_dstM != RNONE) && (wb_dstM < NREGS_ID);
  assign src_a_ok   = (d_srcA != RNONE) && (d_srcA < NREGS_ID);
  assign src_b_ok   = (d_srcB != RNONE) && (d_srcB < NREGS_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
      stat_reg    <= STAT_AOK;
      halted_reg  <= 1'b0;
      retired_reg <= '0;
    end else begin
      // M is written last so it wins when both ports target the same register
      if (we_e) regs_reg[wb_dstE[IDX_W-1:0]] <= wb_valE;
      if (we_m) regs_reg[wb_dstM[IDX_W-1:0]] <= wb_valM;
      if (commit && (wb_stat != STAT_AOK)) begin
        stat_reg   <= wb_stat;
        halted_reg <= 1'b1;
      end
      if (commit && (wb_icode != INOP)) begin
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  always_comb begin
    d_rvalA = '0;
    if (src_a_ok) begin
      if (BYPASS && we_m && (wb_dstM == d_srcA))      d_rvalA = wb_valM;
      else if (BYPASS && we_e && (wb_dstE == d_srcA)) d_rvalA = wb_valE;
      else                                            d_rvalA = regs_reg[d_srcA[IDX_W-1:0]];
    end
  end

  always_comb begin
    d_rvalB = '0;
    if (src_b_ok) begin
      if (BYPASS && we_m && (wb_dstM == d_srcB))      d_rvalB = wb_valM;
      else if (BYPASS && we_e && (wb_dstE == d_srcB)) d_rvalB = wb_valE;
      else                                            d_rvalB = regs_reg[d_srcB[IDX_W-1:0]];
    end
  end

  assign stat_o    = stat_reg;
  assign halted_o  = halted_reg;
  assign retired_o = retired_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs from a behavioural
// model each cycle; a monitor pops and compares them mid-cycle.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        W_stall_i = 1'b1;
  logic [7:0]  wb_icode = 8'h01;
  logic [7:0]  wb_stat = 8'h01;
  logic [31:0] wb_valE = '0;
  logic [31:0] wb_valM = '0;
  logic [7:0]  wb_dstE = 8'h0F;
  logic [7:0]  wb_dstM = 8'h0F;
  logic [7:0]  d_srcA = 8'h0F;
  logic [7:0]  d_srcB = 8'h0F;
  logic [31:0] d_rvalA;
  logic [31:0] d_rvalB;
  logic [7:0]  stat_o;
  logic        halted_o;
  logic [31:0] retired_o;

  wb_regfile dut (
    .clk(clk), .rst(rst), .W_stall_i(W_stall_i),
    .wb_icode(wb_icode), .wb_stat(wb_stat),
    .wb_valE(wb_valE), .wb_valM(wb_valM),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .stat_o(stat_o), .halted_o(halted_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  stat;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  bit   stim_done = 1'b0;

  // Architectural model: plain array plus status/counter
  logic [31:0] m_regs [8];
  logic [7:0]  m_stat;
  logic        m_halted;
  logic [31:0] m_retired;

  function automatic logic [31:0] model_read(input logic [7:0] src, input bit wr,
                                             input logic [7:0] de, input logic [7:0] dm,
                                             input logic [31:0] ve, input logic [31:0] vm);
    if (src > 8'd7) return 32'h0;
    if (wr && dm == src) return vm;
    if (wr && de == src) return ve;
    return m_regs[src[2:0]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_stat = 8'h01;
    m_halted = 1'b0;
    m_retired = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    W_stall_i = $urandom_range(0, 1);
    wb_stat = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    W_stall_i = 1'b1;
    model_reset();
  endtask

  task automatic txn(input logic stall, input logic [7:0] icode, input logic [7:0] st,
                     input logic [31:0] ve, input logic [31:0] vm,
                     input logic [7:0] de, input logic [7:0] dm,
                     input logic [7:0] sa, input logic [7:0] sb);
    exp_t e;
    bit commit;
    bit wr;
    @(posedge clk); #1;
    W_stall_i = stall; wb_icode = icode; wb_stat = st;
    wb_valE = ve; wb_valM = vm; wb_dstE = de; wb_dstM = dm;
    d_srcA = sa; d_srcB = sb;
    commit = !stall && !m_halted;
    wr = commit && (st == 8'h01);
    e.id = n_txn;
    e.a = model_read(sa, wr, de, dm, ve, vm);
    e.b = model_read(sb, wr, de, dm, ve, vm);
    e.stat = m_stat;
    e.halted = m_halted;
    e.retired = m_retired;
    exp_q.push_back(e);
    n_txn++;
    if (wr) begin
      if (de <= 8'd7) m_regs[de[2:0]] = ve;
      if (dm <= 8'd7) m_regs[dm[2:0]] = vm;
    end
    if (commit && st != 8'h01) begin
      m_stat = st;
      m_halted = 1'b1;
    end
    if (commit && icode != 8'h01) m_retired = m_retired + 32'd1;
  endtask

  function automatic logic [7:0] rand_id();
    int r;
    r = $urandom_range(0, 11);
    if (r <= 7) return 8'(r);
    if (r <= 9) return 8'h0F;
    return 8'($urandom_range(8, 14));
  endfunction

  function automatic logic [7:0] rand_stat();
    if ($urandom_range(0, 39) != 0) return 8'h01;
    case ($urandom_range(0, 4))
      0: return 8'h02;
      1: return 8'h03;
      2: return 8'h04;
      3: return 8'h00;
      default: return 8'h09;
    endcase
  endfunction

  // Monitor: one expected record per driven cycle, compared at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks += 5;
        if (d_rvalA !== e.a) begin
          n_fail++;
          $display("FAIL rvalA txn %0d: got %h expected %h", e.id, d_rvalA, e.a);
        end
        if (d_rvalB !== e.b) begin
          n_fail++;
          $display("FAIL rvalB txn %0d: got %h expected %h", e.id, d_rvalB, e.b);
        end
        if (stat_o !== e.stat) begin
          n_fail++;
          $display("FAIL stat txn %0d: got %h expected %h", e.id, stat_o, e.stat);
        end
        if (halted_o !== e.halted) begin
          n_fail++;
          $display("FAIL halted txn %0d: got %b expected %b", e.id, halted_o, e.halted);
        end
        if (retired_o !== e.retired) begin
          n_fail++;
          $display("FAIL retired txn %0d: got %0d expected %0d", e.id, retired_o, e.retired);
        end
        $display("txn %0d: A=%h B=%h stat=%h halted=%b retired=%0d", e.id,
                 d_rvalA, d_rvalB, stat_o, halted_o, retired_o);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Post-reset reads of every ID, stalled so nothing commits
    for (int i = 0; i < 8; i++) txn(1'b1, 8'h06, 8'h01, 32'h1234, 32'h5678, 8'(i), 8'(i), 8'(i), 8'h0F);

    // Dual write with same-cycle bypass, then read back
    txn(1'b0, 8'h06, 8'h01, 32'd5, 32'd7, 8'd0, 8'd3, 8'd3, 8'd0);
    txn(1'b0, 8'h01, 8'h01, 32'd0, 32'd0, 8'h0F, 8'h0F, 8'd0, 8'd3);

    // Same destination on both ports: M wins
    txn(1'b0, 8'h05, 8'h01, 32'hAAAA, 32'hBBBB, 8'd4, 8'd4, 8'd4, 8'd4);
    txn(1'b0, 8'h01, 8'h01, 32'd0, 32'd0, 8'h0F, 8'h0F, 8'd4, 8'd1);

    // Stall: no write, no bypass, no count
    txn(1'b1, 8'h06, 8'h01, 32'd9, 32'd0, 8'd1, 8'h0F, 8'd1, 8'd1);
    txn(1'b0, 8'h01, 8'h01, 32'd0, 32'd0, 8'h0F, 8'h0F, 8'd1, 8'd4);

    // Bubbles with dropped destinations
    for (int i = 0; i < 10; i++) txn(1'b0, 8'h01, 8'h01, $urandom, $urandom, 8'h0F, 8'h09, 8'(i % 8), 8'h09);

    // Fault: no write, status latched, counted once, later commits blocked
    txn(1'b0, 8'h05, 8'h03, 32'd1, 32'd1, 8'd2, 8'h0F, 8'd2, 8'd2);
    for (int i = 0; i < 4; i++) txn(1'b0, 8'h06, 8'h01, 32'hFFFF, 32'hEEEE, 8'd2, 8'd5, 8'd2, 8'd5);
    do_reset();
    txn(1'b0, 8'h01, 8'h01, 32'd0, 32'd0, 8'h0F, 8'h0F, 8'd0, 8'd4);

    // Randomized segments, each starting from reset
    for (int seg = 0; seg < 6; seg++) begin
      for (int k = 0; k < 50; k++) begin
        txn($urandom_range(0, 5) == 0, 8'($urandom_range(0, 11)), rand_stat(),
            $urandom, $urandom, rand_id(), rand_id(), rand_id(), rand_id());
      end
      do_reset();
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d records left, expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
